// File: rtl/idct_pkg.sv
`default_nettype none
// ============================================================================
// idct_pkg : widths, 8x8 IDCT basis matrix, state encoding and round/saturate
//            helpers shared by two_d_idct and idct1d_8.
// Revision  : 1.0
// ============================================================================
package idct_pkg;
   localparam int IN_W  = 12;
   localparam int MID_W = 16;
   localparam int OUT_W = 9;
   localparam int FRAC  = 7;
   localparam int XW    = (IN_W > MID_W) ? IN_W : MID_W;
   localparam int CW    = 16;
   localparam int ACC_W = XW + CW + 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef logic signed [CW-1:0]    cval_t;
   typedef cval_t [7:0][7:0]        cmat_t;
   typedef logic signed [ACC_W-1:0] acc_t;

   localparam acc_t RND_HALF = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam acc_t MID_MAX  = {{(ACC_W-MID_W+1){1'b0}}, {(MID_W-1){1'b1}}};
   localparam acc_t MID_MIN  = {{(ACC_W-MID_W+1){1'b1}}, {(MID_W-1){1'b0}}};
   localparam logic signed [MID_W-1:0] OUT_MAX = MID_W'(2**(OUT_W-1) - 1);
   localparam logic signed [MID_W-1:0] OUT_MIN = MID_W'(-(2**(OUT_W-1)));
   localparam logic signed [MID_W:0]   LS_OFF  = (MID_W+1)'(2**(OUT_W-2));
   localparam logic signed [MID_W:0]   PIX_MAX = (MID_W+1)'(2**(OUT_W-1) - 1);

   // cos(m*pi/16) in Q14 for m = 0..8
   function automatic int cos_q14(input int m);
      case (m)
         0:       return 16384;
         1:       return 16069;
         2:       return 15137;
         3:       return 13623;
         4:       return 11585;
         5:       return 9102;
         6:       return 6270;
         7:       return 3196;
         default: return 0;
      endcase
   endfunction

   // C[k][n]: DC row is 2^FRAC/sqrt(8), others 2^(FRAC-1)*cos((2n+1)k*pi/16)
   function automatic cmat_t build_c();
      cmat_t c;
      int    m;
      int    v;
      bit    neg;
      c = '0;
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < 8; n++) begin
            if (k == 0) begin
               v = (5793 + (1 << (13 - FRAC))) >> (14 - FRAC);
            end else begin
               m   = ((2*n + 1) * k) % 32;
               neg = 1'b0;
               if (m > 16) m = 32 - m;
               if (m > 8) begin
                  m   = 16 - m;
                  neg = 1'b1;
               end
               v = (cos_q14(m) + (1 << (14 - FRAC))) >> (15 - FRAC);
               if (neg) v = -v;
            end
            c[k][n] = cval_t'(v);
         end
      end
      return c;
   endfunction

   localparam cmat_t C = build_c();

   function automatic acc_t round_frac(input acc_t a);
      return (a + RND_HALF) >>> FRAC;
   endfunction

   function automatic logic [MID_W-1:0] sat_mid(input acc_t a);
      if (a > MID_MAX)      return {1'b0, {(MID_W-1){1'b1}}};
      else if (a < MID_MIN) return {1'b1, {(MID_W-1){1'b0}}};
      else                  return a[MID_W-1:0];
   endfunction

   function automatic logic [OUT_W-1:0] sat_out(input logic signed [MID_W-1:0] a);
      if (a > OUT_MAX)      return {1'b0, {(OUT_W-1){1'b1}}};
      else if (a < OUT_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
      else                  return a[OUT_W-1:0];
   endfunction

   function automatic logic [OUT_W-1:0] level_shift_out(input logic signed [MID_W-1:0] a);
      logic signed [MID_W:0] s;
      s = $signed({a[MID_W-1], a}) + LS_OFF;
      if (s[MID_W])         return '0;
      else if (s > PIX_MAX) return {1'b0, {(OUT_W-1){1'b1}}};
      else                  return s[OUT_W-1:0];
   endfunction
endpackage
`default_nettype wire

// File: rtl/idct1d_8.sv
`default_nettype none
// ============================================================================
// idct1d_8 : combinational 8-point 1D IDCT, rounded and saturated to MID_W.
// Revision  : 1.0
// ============================================================================
module idct1d_8
   import idct_pkg::*;
(
   input  logic [7:0][XW-1:0]    x_i,
   output logic [7:0][MID_W-1:0] y_o
);
   acc_t acc;

   always_comb begin
      acc = '0;
      y_o = '0;
      for (int n = 0; n < 8; n++) begin
         acc = '0;
         for (int k = 0; k < 8; k++) begin
            acc = acc + ACC_W'($signed(x_i[k])) * ACC_W'($signed(C[k][n]));
         end
         y_o[n] = sat_mid(round_frac(acc));
      end
   end
endmodule
`default_nettype wire

// File: rtl/two_d_idct.sv
`default_nettype none
// ============================================================================
// two_d_idct : 8x8 2D IDCT, row-column decomposition over one shared 1D IDCT.
//              IDCT_LEVEL_SHIFT_EN: add 128 and clamp pixels to [0,255].
// Revision   : 1.0
// ============================================================================
module two_d_idct
   import idct_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [63:0][IN_W-1:0]  coef_i,
   output logic [63:0][OUT_W-1:0] pix_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i
);
   state_t                 state_q, state_d;
   logic [2:0]             cnt_q, cnt_d;
   logic                   out_valid_q;
   logic [63:0][IN_W-1:0]  coef_q;
   logic [63:0][MID_W-1:0] trans_q;
   logic [63:0][OUT_W-1:0] pix_q;
   logic [7:0][XW-1:0]     row_x;
   logic [7:0][MID_W-1:0]  row_y;
   logic [7:0][OUT_W-1:0]  row_pix;
   logic                   load_en, pass1_en, pass2_en, out_hs;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= (state_q == DONE) && !out_hs;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (in_valid_i) state_d = PASS1;
         end
         PASS1: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = PASS2;
         end
         PASS2: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = DONE;
         end
         DONE: begin
            if (out_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready_o = (state_q == IDLE);
      load_en    = (state_q == IDLE) && in_valid_i;
      pass1_en   = (state_q == PASS1);
      pass2_en   = (state_q == PASS2);
      out_hs     = out_valid_q && out_ready_i;
   end

   // Row cnt of the coefficient buffer in pass 1, of the transpose buffer in pass 2
   always_comb begin
      row_x = '0;
      for (int k = 0; k < 8; k++) begin
         row_x[k] = pass2_en ? XW'($signed(trans_q[{cnt_q, 3'(k)}]))
                             : XW'($signed(coef_q[{cnt_q, 3'(k)}]));
      end
   end

   idct1d_8 u_idct1d (
      .x_i (row_x),
      .y_o (row_y)
   );

   always_comb begin
      row_pix = '0;
      for (int n = 0; n < 8; n++) begin
`ifdef IDCT_LEVEL_SHIFT_EN
         row_pix[n] = level_shift_out(row_y[n]);
`else
         row_pix[n] = sat_out(row_y[n]);
`endif
      end
   end

   // Results are written column-wise, which performs the transpose
   always_ff @(posedge clock) begin
      if (reset) begin
         coef_q  <= '0;
         trans_q <= '0;
         pix_q   <= '0;
      end else begin
         if (load_en) coef_q <= coef_i;
         if (pass1_en) begin
            for (int n = 0; n < 8; n++) trans_q[{3'(n), cnt_q}] <= row_y[n];
         end
         if (pass2_en) begin
            for (int n = 0; n < 8; n++) pix_q[{3'(n), cnt_q}] <= row_pix[n];
         end
      end
   end

   assign pix_o       = pix_q;
   assign out_valid_o = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_two_d_idct.sv
`default_nettype none
// ============================================================================
// tb_two_d_idct : directed and random checks of two_d_idct against a
//                 cosine-based reference model.
// Revision      : 1.0
// ============================================================================
module tb_two_d_idct;
   localparam int IN_W  = 12;
   localparam int OUT_W = 9;
   localparam int FRAC  = 7;
`ifdef IDCT_LEVEL_SHIFT_EN
   localparam int LS = 1;
`else
   localparam int LS = 0;
`endif

   logic                   clock     = 1'b0;
   logic                   reset     = 1'b1;
   logic                   in_valid  = 1'b0;
   logic                   out_ready = 1'b0;
   logic                   in_ready;
   logic                   out_valid;
   logic [63:0][IN_W-1:0]  coef      = '0;
   logic [63:0][OUT_W-1:0] pix;

   int n_assert = 0;
   int n_fail   = 0;
   int cm [8][8];

   always #5 clock = ~clock;

   two_d_idct dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .coef_i      (coef),
      .pix_o       (pix),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_int(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_blk(input string tag, input logic [63:0][OUT_W-1:0] got,
                            input logic [63:0][OUT_W-1:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0][OUT_W-1:0] fill(input int v);
      logic [63:0][OUT_W-1:0] p;
      logic [31:0]            tmp;
      tmp = v;
      for (int i = 0; i < 64; i++) p[i] = tmp[OUT_W-1:0];
      return p;
   endfunction

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // Separable IDCT: columns of the row-transformed block, fixed-point rounding
   function automatic logic [63:0][OUT_W-1:0] ref_idct(input logic [63:0][IN_W-1:0] c);
      longint                 t [64];
      longint                 acc, v;
      logic [31:0]            tmp;
      logic [63:0][OUT_W-1:0] p;
      for (int r = 0; r < 8; r++) begin
         for (int n = 0; n < 8; n++) begin
            acc = 0;
            for (int k = 0; k < 8; k++)
               acc += longint'(cm[k][n]) * longint'($signed(c[8*r+k]));
            v = (acc + (longint'(1) <<< (FRAC-1))) >>> FRAC;
            t[8*n+r] = clamp(v, -32768, 32767);
         end
      end
      for (int r = 0; r < 8; r++) begin
         for (int n = 0; n < 8; n++) begin
            acc = 0;
            for (int k = 0; k < 8; k++)
               acc += longint'(cm[k][n]) * t[8*r+k];
            v = (acc + (longint'(1) <<< (FRAC-1))) >>> FRAC;
            if (LS != 0) v = clamp(v + 128, 0, 255);
            else         v = clamp(v, -256, 255);
            tmp = 32'(v);
            p[8*n+r] = tmp[OUT_W-1:0];
         end
      end
      return p;
   endfunction

   // Present a block, then wait (bounded) for out_valid and check latency/data
   task automatic run_block(input string tag, input logic [63:0][IN_W-1:0] c,
                            input logic [63:0][OUT_W-1:0] exp);
      int cyc;
      coef     = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      coef     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      check_int({tag, "_busy_in_ready"}, in_ready, 0);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         tick();
         cyc++;
      end
      check_int({tag, "_latency"}, cyc, 17);
      check_blk({tag, "_pix"}, pix, exp);
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_int({tag, "_valid_drop"}, out_valid, 0);
      check_int({tag, "_ready_back"}, in_ready, 1);
   endtask

   initial begin
      logic [63:0][IN_W-1:0]  c;
      logic [63:0][OUT_W-1:0] e;
      logic signed [IN_W-1:0] rv;
      real                    x;
      real                    pi;

      pi = 3.14159265358979323846;
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < 8; n++) begin
            if (k == 0) x = (2.0 ** FRAC) / $sqrt(8.0);
            else        x = (2.0 ** (FRAC-1)) * $cos((2*n+1) * k * pi / 16.0);
            cm[k][n] = (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
         end
      end

      reset = 1'b1;
      repeat (3) tick();
      check_int("rst_in_ready", in_ready, 1);
      check_int("rst_out_valid", out_valid, 0);
      check_blk("rst_pix", pix, fill(0));
      reset = 1'b0;
      tick();

      c = '0;
      run_block("zero", c, fill(LS ? 128 : 0));
      release_out("zero");

      c = '0;
      c[0] = 12'd64;
      run_block("dc64", c, fill(LS ? 136 : 8));
      release_out("dc64");

      c = '0;
      c[0] = 12'd2047;
      c[1] = 12'd2047;
      run_block("sat", c, ref_idct(c));
      check_int("sat_pix0", $signed(pix[0]), 255);
      release_out("sat");

      c = '0;
      c[0] = 12'h800;
      run_block("neg", c, fill(LS ? 0 : -253));
      release_out("neg");

      // Output held under back-pressure while a new request is ignored
      c = '0;
      c[0] = 12'd64;
      e = fill(LS ? 136 : 8);
      run_block("hold", c, e);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         coef     = {24{$urandom}};
         tick();
         check_int("hold_valid", out_valid, 1);
         check_int("hold_in_ready", in_ready, 0);
         check_blk("hold_pix", pix, e);
      end
      in_valid = 1'b0;
      release_out("hold");
      tick();
      check_int("hold_idle_valid", out_valid, 0);

      // Reset during the column pass aborts the block
      c = '0;
      c[0] = 12'd500;
      coef     = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (11) tick();
      reset = 1'b1;
      tick();
      check_int("abort_out_valid", out_valid, 0);
      check_int("abort_in_ready", in_ready, 1);
      check_blk("abort_pix", pix, fill(0));
      reset = 1'b0;
      tick();
      c = '0;
      c[0] = 12'd64;
      run_block("post_abort", c, fill(LS ? 136 : 8));
      release_out("post_abort");

      for (int b = 0; b < 1000; b++) begin
         for (int i = 0; i < 64; i++) begin
            rv   = IN_W'($urandom);
            c[i] = rv >>> (3 * (b % 4));
         end
         run_block("rand", c, ref_idct(c));
         release_out("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/two_d_idct.md
Name: two_d_idct

Overview:
- 8x8 two-dimensional inverse DCT. It is the decode-side counterpart of the existing 2D DCT block.
- Accepts one full 64-coefficient block and produces 64 reconstructed pixels.
- Uses row-column decomposition: one 1D IDCT datapath is time-shared over 16 passes and a transpose buffer holds the intermediate results.
- Sits after dequantisation in the decode path and feeds pixel reconstruction.

Parameters:
- IN_W, 12: signed coefficient width.
- MID_W, 16: signed intermediate (transpose buffer) width.
- OUT_W, 9: signed pixel width.
- FRAC, 7: coefficient fractional bits.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  a coefficient block is presented.
- in_ready  out  1  block can be accepted.
- coef  in  64*IN_W  packed [63:0][IN_W-1:0]; index 8*r+u, where r is the row and u the horizontal frequency.
- pix  out  64*OUT_W  packed [63:0][OUT_W-1:0], registered.
- out_valid  out  1  pix holds a complete block.
- out_ready  in  1  consumer accepts pix.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, pix=0, transpose buffer=0.
- States:
  - IDLE: in_ready=1. When in_valid, register coef into an input buffer, then go to PASS1 with cnt=0.
  - PASS1 (8 cycles, cnt 0..7):
    - 1D IDCT on input row cnt (coef[8*cnt +: 8]).
    - Result n is written to trans[8*n+cnt]; this is the transpose.
    - After cnt=7, go to PASS2 with cnt=0.
  - PASS2 (8 cycles):
    - 1D IDCT on trans[8*cnt +: 8].
    - Result n is written to pix[8*n+cnt].
    - After cnt=7, go to DONE.
  - DONE: out_valid=1 and pix held stable. When out_ready, set out_valid=0 and return to IDLE; in_ready=1 on the next cycle.
- Latency: acceptance at edge T gives out_valid high from edge T+17.
- A back-to-back block is accepted no earlier than the cycle after the out handshake.
- in_ready=0 in all states except IDLE. in_valid while busy is ignored; coef changes while busy have no effect.
- 1D IDCT: y[n] = sum over k=0..7 of C[k][n]*x[k].
  - C[0][n] = round(2^FRAC/sqrt(8)) = 45.
  - C[k][n] = round(2^(FRAC-1)*cos((2n+1)k*pi/16)) for k>0 (e.g. C[1][0]=63).
  - Constant coefficients; the accumulator is wide enough to be exact (at least IN_W+FRAC+4 bits).
  - Rounding: add 2^(FRAC-1), then arithmetic shift right by FRAC (floor).
  - PASS1 result saturates to signed MID_W. PASS2 result saturates to signed OUT_W, i.e. [-256,255].
- Reset mid-operation: abort immediately and return to reset values. A partial block is never output.
- out_ready while not out_valid is ignored.

Optional Feature:
- Macro IDCT_LEVEL_SHIFT_EN.
- When defined: the PASS2 rounded result has +2^(OUT_W-2) added (=128), is clamped to [0, 2^(OUT_W-1)-1] = [0,255], and pix is interpreted as unsigned 8-bit in the low bits with MSB=0.
- When undefined: signed saturation to [-256,255] as above.

Decomposition:
- Package idct_pkg holds:
  - the 8x8 coefficient constant array C (localparam, FRAC-dependent);
  - the state enum (IDLE, PASS1, PASS2, DONE);
  - round/saturate helper functions.
- Sub-module idct1d_8 is purely combinational: 8 signed inputs of width max(IN_W,MID_W) to 8 rounded outputs of width MID_W. The parent performs the final saturation.

Test Plan:
- All-zero coef, in_valid pulse -> out_valid at T+17, all 64 pix = 0; with level shift, all pix = 128.
- coef[0]=64, rest 0 -> PASS1 row-0 values 23; all 64 pix = 8 (136 with IDCT_LEVEL_SHIFT_EN).
- coef[0]=2047, coef[1]=2047 -> pix[0] = 255, saturated (pre-saturation 607); then coef[0]=-2048 only -> all pix = -253.
- Hold out_ready=0 for 20 cycles after out_valid -> pix stable, out_valid stays 1, in_ready=0, a second in_valid is ignored; out_ready=1 -> out_valid drops, in_ready=1 the next cycle.
- Assert reset during PASS2 (cnt=3) -> next cycle out_valid=0, in_ready=1, pix=0; a fresh DC=64 block then yields all 8.
- Compare against the reference model for 1000 random coefficient blocks (IN_W range) -> bit-exact per the rounding/saturation rules.
